mem_access_stage: RTL and testbench

Pipeline MEM stage of the RISC-V core, fed by the EX/MEM register outputs. It performs loads and stores over a request/acknowledge data-memory port and generates byte lanes and load extension from funct3. It stalls the upstream pipeline while an access is outstanding and owns the MEM/WB register that delivers the final write-back value.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the request/ack data-memory port, aligns store lanes,
// extends load data and owns the MEM/WB register.
module mem_access_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        mem_regwrite,
  input  logic [1:0]  mem_memtoreg,
  input  logic [31:0] mem_aluresult,
  input  logic [31:0] mem_rs2_data,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] reg_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_writedata,
  output logic        wb_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_rdata;
  logic        w_capture;

  logic        w_is_store;
  logic        w_mem_op;
  logic        w_legal;
  logic        w_aligned;
  logic        w_access;
  logic        w_fault;
  logic [1:0]  w_off;
  logic [7:0]  w_bytes [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_value;

  // A load wins when both read and write are flagged.
  assign w_is_store = mem_memwrite & ~mem_memread;
  assign w_mem_op   = mem_memread | mem_memwrite;
  assign w_off      = mem_aluresult[1:0];

  always_comb begin
    w_legal = 1'b0;
    if (mem_memread) begin
      case (mem_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end else if (mem_memwrite) begin
      w_legal = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) || (mem_funct3 == 3'b010);
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    case (mem_funct3[1:0])
      2'b01:   w_aligned = ~w_off[0];
      2'b10:   w_aligned = (w_off == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_access = w_mem_op & w_legal & w_aligned;
  assign w_fault  = w_mem_op & ~(w_legal & w_aligned);

  // Bus-side address and store lanes; stable while upstream is frozen.
  assign dmem_we   = w_is_store;
  assign dmem_addr = {mem_aluresult[31:2], 2'b00};

  always_comb begin
    dmem_wdata = mem_rs2_data;
    case (mem_funct3[1:0])
      2'b00:   dmem_wdata = {4{mem_rs2_data[7:0]}};
      2'b01:   dmem_wdata = {2{mem_rs2_data[15:0]}};
      default: dmem_wdata = mem_rs2_data;
    endcase
  end

  always_comb begin
    dmem_wstrb = 4'b0000;
    if (w_is_store) begin
      case (mem_funct3)
        3'b000:  dmem_wstrb = 4'b0001 << w_off;
        3'b001:  dmem_wstrb = 4'b0011 << w_off;
        3'b010:  dmem_wstrb = 4'b1111;
        default: dmem_wstrb = 4'b0000;
      endcase
    end
  end

  // Handshake FSM; reset forces the bus request and stall low in the same cycle.
  always_comb begin
    w_state_next = r_state;
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          dmem_req  = 1'b1;
          mem_stall = 1'b1;
          if (dmem_ack) begin
            w_capture    = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ack) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) r_rdata <= dmem_rdata;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_bytes[gi] = r_rdata[8*gi +: 8];
  end

  assign w_byte = w_bytes[w_off];
  assign w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    w_load_data = r_rdata;
    case (mem_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  always_comb begin
    w_wb_value = mem_aluresult;
    case (mem_memtoreg)
      2'b01:   w_wb_value = w_load_data;
      2'b10:   w_wb_value = reg_pc;
      default: w_wb_value = mem_aluresult;
    endcase
  end

  // Stall cycles retire bubbles so an access writes back exactly once, from DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_regwrite  <= 1'b0;
      wb_rd        <= 5'd0;
      wb_writedata <= 32'd0;
      wb_fault     <= 1'b0;
    end else if (mem_stall) begin
      wb_regwrite <= 1'b0;
      wb_fault    <= 1'b0;
    end else begin
      wb_regwrite  <= mem_regwrite & ~w_fault;
      wb_rd        <= mem_rd;
      wb_writedata <= w_wb_value;
      wb_fault     <= w_fault;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads with wait states, faults,
// ALU write-back, back-to-back accesses and reset during a pending access.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_memread, mem_memwrite, mem_regwrite;
  logic [1:0]  mem_memtoreg;
  logic [31:0] mem_aluresult, mem_rs2_data, reg_pc;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_regwrite, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_writedata;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_aluresult(mem_aluresult), .mem_rs2_data(mem_rs2_data),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd), .reg_pc(reg_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_writedata(wb_writedata), .wb_fault(wb_fault)
  );

  task automatic clear_inputs();
    mem_memread = 0; mem_memwrite = 0; mem_regwrite = 0; mem_memtoreg = 2'b00;
    mem_aluresult = 0; mem_rs2_data = 0; mem_funct3 = 3'b000; mem_rd = 0;
    reg_pc = 0; dmem_ack = 0;
  endtask

  // Called just after a falling edge with the instruction applied. Acks in the
  // request cycle numbered ack_at (0 = first) and returns inside the DONE cycle.
  task automatic run_access(input int ack_at, output logic first_req, output logic [31:0] first_wb,
                            output int stalls, output int writes);
    stalls = 0; writes = 0; first_req = 0; first_wb = 0;
    dmem_ack = (ack_at == 0);
    for (int c = 0; c < 50; c++) begin
      #1;
      if (c == 0) begin first_req = dmem_req; first_wb = wb_writedata; end
      if (mem_stall) stalls++;
      if (wb_regwrite) writes++;
      if (!mem_stall) break;
      @(negedge clock);
      dmem_ack = (c + 1 == ack_at);
    end
    dmem_ack = 0;
  endtask

  task automatic test_reset();
    @(negedge clock); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", dmem_req); else passed++;
    total++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %b exp 0", mem_stall); else passed++;
    @(negedge clock); reset = 0; clear_inputs(); #1;
    total++; if (wb_regwrite !== 1'b0) $display("FAIL rst_wb_regwrite: got %b exp 0", wb_regwrite); else passed++;
    total++; if (wb_rd !== 5'd0) $display("FAIL rst_wb_rd: got %h exp 0", wb_rd); else passed++;
    total++; if (wb_writedata !== 32'd0) $display("FAIL rst_wb_data: got %h exp 0", wb_writedata); else passed++;
    total++; if (wb_fault !== 1'b0) $display("FAIL rst_wb_fault: got %b exp 0", wb_fault); else passed++;
    $display("txn reset: req=%b stall=%b wb=%h", dmem_req, mem_stall, wb_writedata);
  endtask

  task automatic test_store_byte();
    logic fr; logic [31:0] fw; int st, wr;
    @(negedge clock); clear_inputs();
    mem_memwrite = 1; mem_funct3 = 3'b000; mem_aluresult = 32'h103; mem_rs2_data = 32'hA5;
    run_access(0, fr, fw, st, wr);
    total++; if (fr !== 1'b1) $display("FAIL sb_req: got %b exp 1", fr); else passed++;
    total++; if (st !== 1) $display("FAIL sb_stalls: got %0d exp 1", st); else passed++;
    total++; if (dmem_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h exp a5a5a5a5", dmem_wdata); else passed++;
    total++; if (dmem_wstrb !== 4'b1000) $display("FAIL sb_wstrb: got %b exp 1000", dmem_wstrb); else passed++;
    total++; if (dmem_we !== 1'b1) $display("FAIL sb_we: got %b exp 1", dmem_we); else passed++;
    total++; if (dmem_addr !== 32'h100) $display("FAIL sb_addr: got %h exp 00000100", dmem_addr); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL sb_done_req: got %b exp 0", dmem_req); else passed++;
    @(negedge clock); clear_inputs(); #1;
    total++; if (wb_regwrite !== 1'b0) $display("FAIL sb_wb_regwrite: got %b exp 0", wb_regwrite); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL sb_no_reissue: got %b exp 0", dmem_req); else passed++;
    $display("txn sb: stalls=%0d wdata=%h wstrb=%b", st, dmem_wdata, dmem_wstrb);
  endtask

  task automatic test_load_byte();
    logic fr; logic [31:0] fw; int st, wr;
    // LB with three wait cycles after the first request cycle
    @(negedge clock); clear_inputs();
    mem_memread = 1; mem_funct3 = 3'b000; mem_aluresult = 32'h102; mem_regwrite = 1;
    mem_rd = 5'd5; mem_memtoreg = 2'b01; dmem_rdata = 32'h11802233;
    run_access(3, fr, fw, st, wr);
    total++; if (st !== 4) $display("FAIL lb_stalls: got %0d exp 4", st); else passed++;
    @(negedge clock); clear_inputs(); #1;
    if (wb_regwrite) wr++;
    total++; if (wb_writedata !== 32'hFFFFFF80) $display("FAIL lb_data: got %h exp ffffff80", wb_writedata); else passed++;
    total++; if (wb_rd !== 5'd5) $display("FAIL lb_rd: got %h exp 05", wb_rd); else passed++;
    @(negedge clock); #1;
    if (wb_regwrite) wr++;
    total++; if (wr !== 1) $display("FAIL lb_writes: got %0d exp 1", wr); else passed++;
    $display("txn lb: stalls=%0d data=%h writes=%0d", st, wb_writedata, wr);
    // LBU at the same address
    @(negedge clock); clear_inputs();
    mem_memread = 1; mem_funct3 = 3'b100; mem_aluresult = 32'h102; mem_regwrite = 1;
    mem_rd = 5'd6; mem_memtoreg = 2'b01;
    run_access(0, fr, fw, st, wr);
    total++; if (st !== 1) $display("FAIL lbu_stalls: got %0d exp 1", st); else passed++;
    @(negedge clock); clear_inputs(); #1;
    if (wb_regwrite) wr++;
    total++; if (wb_writedata !== 32'h00000080) $display("FAIL lbu_data: got %h exp 00000080", wb_writedata); else passed++;
    @(negedge clock); #1;
    if (wb_regwrite) wr++;
    total++; if (wr !== 1) $display("FAIL lbu_writes: got %0d exp 1", wr); else passed++;
    $display("txn lbu: stalls=%0d data=%h writes=%0d", st, wb_writedata, wr);
  endtask

  task automatic test_fault();
    @(negedge clock); clear_inputs();
    mem_memread = 1; mem_funct3 = 3'b010; mem_aluresult = 32'h2; mem_regwrite = 1;
    mem_rd = 5'd9; mem_memtoreg = 2'b01; #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL lw_misal_req: got %b exp 0", dmem_req); else passed++;
    total++; if (mem_stall !== 1'b0) $display("FAIL lw_misal_stall: got %b exp 0", mem_stall); else passed++;
    @(negedge clock); mem_funct3 = 3'b011; mem_aluresult = 32'h100; #1;
    total++; if (wb_fault !== 1'b1) $display("FAIL lw_misal_fault: got %b exp 1", wb_fault); else passed++;
    total++; if (wb_regwrite !== 1'b0) $display("FAIL lw_misal_regwrite: got %b exp 0", wb_regwrite); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL ld011_req: got %b exp 0", dmem_req); else passed++;
    total++; if (mem_stall !== 1'b0) $display("FAIL ld011_stall: got %b exp 0", mem_stall); else passed++;
    @(negedge clock); mem_memread = 0; mem_memwrite = 1; mem_regwrite = 0;
    mem_funct3 = 3'b001; mem_aluresult = 32'h101; #1;
    total++; if (wb_fault !== 1'b1) $display("FAIL ld011_fault: got %b exp 1", wb_fault); else passed++;
    total++; if (wb_regwrite !== 1'b0) $display("FAIL ld011_regwrite: got %b exp 0", wb_regwrite); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL sh_misal_req: got %b exp 0", dmem_req); else passed++;
    @(negedge clock); clear_inputs(); #1;
    total++; if (wb_fault !== 1'b1) $display("FAIL sh_misal_fault: got %b exp 1", wb_fault); else passed++;
    @(negedge clock); #1;
    total++; if (wb_fault !== 1'b0) $display("FAIL fault_one_cycle: got %b exp 0", wb_fault); else passed++;
    $display("txn faults: lw@2, funct3=011 load, sh@101 retired as bubbles");
  endtask

  task automatic test_alu_writeback();
    @(negedge clock); clear_inputs();
    mem_regwrite = 1; mem_rd = 5'd3; mem_memtoreg = 2'b10; reg_pc = 32'h44;
    mem_aluresult = 32'h1234; dmem_ack = 1; #1;
    total++; if (mem_stall !== 1'b0) $display("FAIL alu_stall: got %b exp 0", mem_stall); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL alu_req: got %b exp 0", dmem_req); else passed++;
    @(negedge clock); mem_memtoreg = 2'b00; mem_rd = 5'd4; #1;
    total++; if (wb_writedata !== 32'h44) $display("FAIL alu_pc: got %h exp 00000044", wb_writedata); else passed++;
    total++; if (wb_rd !== 5'd3) $display("FAIL alu_pc_rd: got %h exp 03", wb_rd); else passed++;
    total++; if (wb_regwrite !== 1'b1) $display("FAIL alu_pc_regwrite: got %b exp 1", wb_regwrite); else passed++;
    @(negedge clock); mem_memtoreg = 2'b11; mem_aluresult = 32'hCAFE; mem_rd = 5'd6; #1;
    total++; if (wb_writedata !== 32'h1234) $display("FAIL alu_00: got %h exp 00001234", wb_writedata); else passed++;
    @(negedge clock); clear_inputs(); #1;
    total++; if (wb_writedata !== 32'hCAFE) $display("FAIL alu_11: got %h exp 0000cafe", wb_writedata); else passed++;
    $display("txn alu: memtoreg 10/00/11 write-back, last=%h", wb_writedata);
  endtask

  task automatic test_back_to_back();
    logic fr; logic [31:0] fw; int st, wr;
    @(negedge clock); clear_inputs();
    mem_memread = 1; mem_funct3 = 3'b010; mem_aluresult = 32'h200; mem_regwrite = 1;
    mem_rd = 5'd7; mem_memtoreg = 2'b01; dmem_rdata = 32'hDEADBEEF;
    run_access(0, fr, fw, st, wr);
    total++; if (st !== 1) $display("FAIL b2b_lw_stalls: got %0d exp 1", st); else passed++;
    @(negedge clock);
    mem_funct3 = 3'b001; mem_aluresult = 32'h202; mem_rd = 5'd8; dmem_rdata = 32'h80011234;
    run_access(1, fr, fw, st, wr);
    total++; if (fr !== 1'b1) $display("FAIL b2b_second_req: got %b exp 1", fr); else passed++;
    total++; if (fw !== 32'hDEADBEEF) $display("FAIL b2b_lw_data: got %h exp deadbeef", fw); else passed++;
    total++; if (st !== 2) $display("FAIL b2b_lh_stalls: got %0d exp 2", st); else passed++;
    @(negedge clock); clear_inputs(); #1;
    total++; if (wb_writedata !== 32'hFFFF8001) $display("FAIL b2b_lh_data: got %h exp ffff8001", wb_writedata); else passed++;
    total++; if (wb_rd !== 5'd8) $display("FAIL b2b_lh_rd: got %h exp 08", wb_rd); else passed++;
    $display("txn b2b: lw=%h lh=%h", fw, wb_writedata);
  endtask

  task automatic test_reset_in_wait();
    logic fr; logic [31:0] fw; int st, wr;
    @(negedge clock); clear_inputs();
    mem_memread = 1; mem_funct3 = 3'b010; mem_aluresult = 32'h300; mem_regwrite = 1;
    mem_rd = 5'd10; mem_memtoreg = 2'b01; #1;
    total++; if (dmem_req !== 1'b1) $display("FAIL rw_idle_req: got %b exp 1", dmem_req); else passed++;
    @(negedge clock); #1;
    total++; if (mem_stall !== 1'b1) $display("FAIL rw_wait_stall: got %b exp 1", mem_stall); else passed++;
    @(negedge clock); reset = 1; #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rw_reset_req: got %b exp 0", dmem_req); else passed++;
    @(negedge clock); reset = 0; clear_inputs(); #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rw_after_req: got %b exp 0", dmem_req); else passed++;
    total++; if (mem_stall !== 1'b0) $display("FAIL rw_after_stall: got %b exp 0", mem_stall); else passed++;
    total++; if (wb_writedata !== 32'd0) $display("FAIL rw_after_wb: got %h exp 0", wb_writedata); else passed++;
    @(negedge clock);
    mem_memwrite = 1; mem_funct3 = 3'b010; mem_aluresult = 32'h304; mem_rs2_data = 32'h12345678;
    run_access(0, fr, fw, st, wr);
    total++; if (fr !== 1'b1) $display("FAIL sw_req: got %b exp 1", fr); else passed++;
    total++; if (st !== 1) $display("FAIL sw_stalls: got %0d exp 1", st); else passed++;
    total++; if (dmem_wdata !== 32'h12345678) $display("FAIL sw_wdata: got %h exp 12345678", dmem_wdata); else passed++;
    total++; if (dmem_wstrb !== 4'b1111) $display("FAIL sw_wstrb: got %b exp 1111", dmem_wstrb); else passed++;
    total++; if (dmem_addr !== 32'h304) $display("FAIL sw_addr: got %h exp 00000304", dmem_addr); else passed++;
    @(negedge clock); clear_inputs(); #1;
    total++; if (wb_fault !== 1'b0) $display("FAIL sw_fault: got %b exp 0", wb_fault); else passed++;
    $display("txn reset-in-wait then sw: stalls=%0d wstrb=%b", st, dmem_wstrb);
  endtask

  initial begin
    clear_inputs();
    dmem_rdata = 32'd0;
    reset = 1; mem_memread = 1; mem_funct3 = 3'b010;
    test_reset();
    test_store_byte();
    test_load_byte();
    test_fault();
    test_alu_writeback();
    test_back_to_back();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
